// File: rtl/airlock_pressurize.sv
// -----------------------------------------------------------------------------
// airlock_pressurize
//
// Fill-side controller for an airlock chamber. Opens the fill valve while the
// chamber is sealed and filling is requested, counts active fill cycles, and
// declares the chamber pressurized once FILL_CYCLES active cycles have elapsed.
// A dropped request pauses the fill without losing progress. An open door or
// an evacuation request during the fill aborts it. When done, control is
// handed back to the evacuation controller on its request.
//
// Ports
//   Clock                 in   single clock, rising edge
//   Reset                 in   synchronous, active-high
//   begin_Pressurization  in   level request to fill the chamber
//   begin_Evacuation      in   level request from the evacuation controller
//   InnerClosed           in   inner door closed when 1
//   OuterClosed           in   outer door closed when 1
//   Pressurization        out  fill valve open (FILL)
//   Pressurized           out  chamber at pressure (DONE)
//   Aborted               out  fill aborted, waiting for request release
//   Progress              out  fill cycles completed (counter value)
// -----------------------------------------------------------------------------
module airlock_pressurize #(
  parameter int unsigned FILL_CYCLES = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             begin_Pressurization,
  input  logic             begin_Evacuation,
  input  logic             InnerClosed,
  input  logic             OuterClosed,
  output logic             Pressurization,
  output logic             Pressurized,
  output logic             Aborted,
  output logic [CNT_W-1:0] Progress
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    HOLD  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FILL_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic doors_closed;
  logic interrupt;

  assign doors_closed = InnerClosed && OuterClosed;
  // Anything that makes continuing the fill unsafe: a door opened or the
  // evacuation side asked for the chamber.
  assign interrupt    = !doors_closed || begin_Evacuation;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of process ordering.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch
    // can be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (begin_Pressurization && !begin_Evacuation && doors_closed) begin
          state_d = FILL;
        end
      end

      FILL: begin
        // Abort outranks hold, and hold outranks completion.
        if (interrupt) begin
          state_d = ABORT;
          cnt_d   = '0;
        end else if (!begin_Pressurization) begin
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = CNT_FULL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (interrupt) begin
          state_d = ABORT;
          cnt_d   = '0;
        end else if (begin_Pressurization) begin
          state_d = FILL;
        end
      end

      DONE: begin
        // Door state is deliberately ignored here: once at pressure, only the
        // evacuation controller can take the chamber back.
        cnt_d = CNT_FULL;
        if (begin_Evacuation) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      ABORT: begin
        cnt_d = '0;
        if (!begin_Pressurization) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs: decoded from registered state and counter only.
  assign Pressurization = (state_q == FILL);
  assign Pressurized    = (state_q == DONE);
  assign Aborted        = (state_q == ABORT);
  assign Progress       = cnt_q;

endmodule
